// File: rtl/nubus_bswitch_sequencer_if.sv
// Request/grant and switch-enable bundle between the NuBus protocol engines and the bus switch sequencer.
// The sequencer takes the slave side; whatever drives the requests takes the master side.
interface nubus_bswitch_sequencer_if;
    logic [2:0] req;
    logic       isolate;
    logic       err_clr;
    logic [3:0] oe_n;
    logic [2:0] gnt;
    logic       busy;
    logic       wdog_err;

    modport master (
        output req, isolate, err_clr,
        input  oe_n, gnt, busy, wdog_err
    );

    modport slave (
        input  req, isolate, err_clr,
        output oe_n, gnt, busy, wdog_err
    );
endinterface

// File: rtl/nubus_bswitch_sequencer.sv
// Round-robin owner of the NuBus quad bus switch oe_n lines, with a break-before-make dead time.
// Defining BSWITCH_WATCHDOG_EN adds an ownership watchdog with per-requester lockout.
module nubus_bswitch_sequencer #(
    parameter logic [3:0] MASK0    = 4'b0011,
    parameter logic [3:0] MASK1    = 4'b1111,
    parameter logic [3:0] MASK2    = 4'b1100,
    parameter int         DEAD_CYC = 2,
    parameter int         WDOG_CYC = 1024
) (
    input  logic                          nub_clkn,
    input  logic                          nub_resetn,
    nubus_bswitch_sequencer_if.slave      bus
);

    typedef enum logic [1:0] {IDLE, SETTLE, OWN, DRAIN} state_t;

    localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYC - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] oeN_q, oeN_d;
    logic [2:0] gnt_q, gnt_d;
    logic       busy_q;

    logic [2:0] eligible;
    logic [2:0] ownerOh;
    logic       reqOwner;
    logic       wdogHit;
    logic       selFound;
    logic [1:0] selIdx;
    logic [2:0] cand;

    function automatic logic [3:0] maskOf(input logic [1:0] idx);
        case (idx)
            2'd0:    maskOf = MASK0;
            2'd1:    maskOf = MASK1;
            default: maskOf = MASK2;
        endcase
    endfunction

    assign ownerOh  = 3'b001 << owner_q;
    assign reqOwner = |(bus.req & ownerOh);

`ifdef BSWITCH_WATCHDOG_EN
    logic [15:0] wdogCnt_q, wdogCnt_d;
    logic [2:0]  lockout_q, lockout_d;
    logic        wdogErr_q, wdogErr_d;

    assign wdogHit  = (state_q == OWN) && (wdogCnt_q == 16'(WDOG_CYC - 1));
    assign eligible = bus.req & ~lockout_q;

    // A lockout bit only clears once its request has been seen low; a same-cycle set wins.
    always_comb begin
        wdogCnt_d = wdogCnt_q;
        lockout_d = (lockout_q & bus.req) | (wdogHit ? ownerOh : 3'b000);
        wdogErr_d = wdogErr_q;
        if (state_q == SETTLE && state_d == OWN) begin
            wdogCnt_d = 16'd0;
        end else if (state_q == OWN) begin
            wdogCnt_d = wdogCnt_q + 16'd1;
        end
        if (wdogHit) begin
            wdogErr_d = 1'b1;
        end else if (bus.err_clr) begin
            wdogErr_d = 1'b0;
        end
    end

    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            wdogCnt_q <= 16'd0;
            lockout_q <= 3'b000;
            wdogErr_q <= 1'b0;
        end else begin
            wdogCnt_q <= wdogCnt_d;
            lockout_q <= lockout_d;
            wdogErr_q <= wdogErr_d;
        end
    end

    assign bus.wdog_err = wdogErr_q;
`else
    localparam int unusedWdogCyc = WDOG_CYC;
    logic unusedErrClr;

    assign unusedErrClr = bus.err_clr;
    assign wdogHit      = 1'b0;
    assign eligible     = bus.req;
    assign bus.wdog_err = 1'b0;
`endif

    // Round-robin search starting at the pointer, wrapping 0->1->2->0.
    always_comb begin
        selFound = 1'b0;
        selIdx   = ptr_q;
        cand     = 3'd0;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, ptr_q} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!selFound && eligible[cand[1:0]]) begin
                selFound = 1'b1;
                selIdx   = cand[1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        oeN_d   = oeN_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (!bus.isolate && selFound) begin
                    owner_d = selIdx;
                    cnt_d   = DEAD_LOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // An abort here leaves the pointer alone, since nobody was ever enabled.
                if (!reqOwner || bus.isolate) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = OWN;
                    oeN_d   = ~maskOf(owner_q);
                    gnt_d   = ownerOh;
                    ptr_d   = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            OWN: begin
                if (!reqOwner || bus.isolate || wdogHit) begin
                    state_d = DRAIN;
                    cnt_d   = DEAD_LOAD;
                    oeN_d   = 4'hF;
                    gnt_d   = 3'b000;
                end
            end
            DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                oeN_d   = 4'hF;
                gnt_d   = 3'b000;
            end
        endcase
    end

    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            oeN_q   <= 4'hF;
            gnt_q   <= 3'b000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            oeN_q   <= oeN_d;
            gnt_q   <= gnt_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.oe_n = oeN_q;
    assign bus.gnt  = gnt_q;
    assign bus.busy = busy_q;

endmodule
